// File: rtl/intc_vectored_pkg.sv
// rtl/intc_vectored_pkg.sv - shared state encodings, cfg_sel codes and default vectors for intc_vectored
package intc_vectored_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } intc_state_t;

    localparam logic [1:0] CFG_IE   = 2'd0;
    localparam logic [1:0] CFG_MODE = 2'd1;
    localparam logic [1:0] CFG_CLR  = 2'd2;
    localparam logic [1:0] CFG_SET  = 2'd3;

    localparam logic [5:0] NMI_VECTOR   = 6'h3E;
    localparam logic [5:0] IRQ_VEC_BASE = 6'h2E;

endpackage

// File: rtl/intc_prio_enc.sv
// rtl/intc_prio_enc.sv - combinational highest-index priority encoder
module intc_prio_enc #(
    parameter int N    = 16,
    parameter int ID_W = 4
) (
    input  logic [N-1:0]    req,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    // Ascending scan so the highest set index is the one left in id
    always_comb begin
        valid = |req;
        id    = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/intc_vectored.sv
// rtl/intc_vectored.sv - vectored prioritised interrupt controller; optional input synchronisers via INTC_SYNC_EN
module intc_vectored #(
    parameter int NUM_IRQ  = 16,
    parameter int VEC_BITS = 6,
    parameter logic [VEC_BITS-1:0] IRQ_VEC_BASE = VEC_BITS'(intc_vectored_pkg::IRQ_VEC_BASE),
    parameter logic [VEC_BITS-1:0] NMI_VECTOR   = VEC_BITS'(intc_vectored_pkg::NMI_VECTOR)
) (
    input  logic                MCLK,
    input  logic                reset_n,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic                nmi_in,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_sel,
    input  logic [NUM_IRQ-1:0]  cfg_wdata,
    input  logic                INTACK,
    output logic                INT,
    output logic                NMI,
    output logic [VEC_BITS-1:0] IntAddrLSBs,
    output logic [NUM_IRQ-1:0]  irq_ack,
    output logic [NUM_IRQ-1:0]  ie_q,
    output logic [NUM_IRQ-1:0]  mode_q,
    output logic [NUM_IRQ-1:0]  ifg_q
);

    import intc_vectored_pkg::*;

    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0]  irq_s;
    logic                nmi_s;

    logic [NUM_IRQ-1:0]  ie_d, mode_d, ifg_d;
    logic [NUM_IRQ-1:0]  irq_prev_q, irq_prev_d;
    logic                nmi_prev_q, nmi_prev_d;
    logic                nmi_pend_q, nmi_pend_d;
    intc_state_t         state_q, state_d;
    logic                int_q, int_d;
    logic                nmi_q, nmi_d;
    logic [VEC_BITS-1:0] vec_q, vec_d;
    logic [NUM_IRQ-1:0]  ack_q, ack_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                sel_nmi_q, sel_nmi_d;

    logic [NUM_IRQ-1:0]  pending;
    logic                win_valid;
    logic [ID_W-1:0]     win_id;
    logic [NUM_IRQ-1:0]  ack_clr;
    logic                nmi_ack;

`ifdef INTC_SYNC_EN
    logic [NUM_IRQ-1:0] irq_s1_q, irq_s2_q;
    logic               nmi_s1_q, nmi_s2_q;

    // Two-flop synchronisers ahead of edge detection for asynchronous sources
    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            irq_s1_q <= '0;
            irq_s2_q <= '0;
            nmi_s1_q <= 1'b0;
            nmi_s2_q <= 1'b0;
        end else begin
            irq_s1_q <= irq;
            irq_s2_q <= irq_s1_q;
            nmi_s1_q <= nmi_in;
            nmi_s2_q <= nmi_s1_q;
        end
    end

    assign irq_s = irq_s2_q;
    assign nmi_s = nmi_s2_q;
`else
    assign irq_s = irq;
    assign nmi_s = nmi_in;
`endif

    assign pending = ifg_q & ie_q;

    intc_prio_enc #(
        .N    (NUM_IRQ),
        .ID_W (ID_W)
    ) u_prio_enc (
        .req   (pending),
        .valid (win_valid),
        .id    (win_id)
    );

    // Arbitration / acknowledge state machine; every CPU-facing output is a flop
    always_comb begin
        state_d   = state_q;
        int_d     = int_q;
        nmi_d     = nmi_q;
        vec_d     = vec_q;
        id_d      = id_q;
        sel_nmi_d = sel_nmi_q;
        ack_d     = '0;
        ack_clr   = '0;
        nmi_ack   = 1'b0;
        case (state_q)
            IDLE, PEND: begin
                if (state_q == PEND && INTACK) begin
                    int_d   = 1'b0;
                    nmi_d   = 1'b0;
                    state_d = ACK;
                    if (sel_nmi_q) begin
                        nmi_ack = 1'b1;
                    end else begin
                        ack_d   = NUM_IRQ'(1) << id_q;
                        ack_clr = NUM_IRQ'(1) << id_q;
                    end
                end else if (nmi_pend_q) begin
                    nmi_d     = 1'b1;
                    int_d     = 1'b0;
                    sel_nmi_d = 1'b1;
                    vec_d     = NMI_VECTOR;
                    state_d   = PEND;
                end else if (win_valid) begin
                    int_d     = 1'b1;
                    nmi_d     = 1'b0;
                    sel_nmi_d = 1'b0;
                    id_d      = win_id;
                    vec_d     = IRQ_VEC_BASE + VEC_BITS'(win_id);
                    state_d   = PEND;
                end else begin
                    int_d   = 1'b0;
                    nmi_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            ACK: begin
                if (!INTACK) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                int_d   = 1'b0;
                nmi_d   = 1'b0;
            end
        endcase
    end

    // Flag and configuration update; a set on the same cycle as a clear always survives
    always_comb begin
        logic [NUM_IRQ-1:0] set_v;
        logic [NUM_IRQ-1:0] clr_v;
        logic [NUM_IRQ-1:0] edge_next;

        ie_d       = ie_q;
        mode_d     = mode_q;
        irq_prev_d = irq_s;
        nmi_prev_d = nmi_s;

        set_v = irq_s & ~irq_prev_q;
        clr_v = ack_clr;
        if (cfg_we && cfg_sel == CFG_SET) set_v = set_v | cfg_wdata;
        if (cfg_we && cfg_sel == CFG_CLR) clr_v = clr_v | cfg_wdata;
        if (cfg_we && cfg_sel == CFG_IE)   ie_d   = cfg_wdata;
        if (cfg_we && cfg_sel == CFG_MODE) mode_d = cfg_wdata;

        edge_next = (ifg_q & ~clr_v) | set_v;
        ifg_d     = (mode_q & edge_next) | (~mode_q & irq_s);
        // Edge channels being switched to level lose any stored event
        if (cfg_we && cfg_sel == CFG_MODE) ifg_d = ifg_d & ~(mode_q & ~cfg_wdata);

        nmi_pend_d = (nmi_s & ~nmi_prev_q) | (nmi_pend_q & ~nmi_ack);
    end

    // State and register file
    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            ie_q       <= '0;
            mode_q     <= '0;
            ifg_q      <= '0;
            irq_prev_q <= '0;
            nmi_prev_q <= 1'b0;
            nmi_pend_q <= 1'b0;
            state_q    <= IDLE;
            int_q      <= 1'b0;
            nmi_q      <= 1'b0;
            vec_q      <= '0;
            ack_q      <= '0;
            id_q       <= '0;
            sel_nmi_q  <= 1'b0;
        end else begin
            ie_q       <= ie_d;
            mode_q     <= mode_d;
            ifg_q      <= ifg_d;
            irq_prev_q <= irq_prev_d;
            nmi_prev_q <= nmi_prev_d;
            nmi_pend_q <= nmi_pend_d;
            state_q    <= state_d;
            int_q      <= int_d;
            nmi_q      <= nmi_d;
            vec_q      <= vec_d;
            ack_q      <= ack_d;
            id_q       <= id_d;
            sel_nmi_q  <= sel_nmi_d;
        end
    end

    assign INT         = int_q;
    assign NMI         = nmi_q;
    assign IntAddrLSBs = vec_q;
    assign irq_ack     = ack_q;

endmodule
